// File: rtl/xor_64.sv
// rtl/xor_64.sv - registered 64-bit bitwise XOR with optional Y86 flags (XOR64_FLAGS_EN)
module xor_64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             out_valid,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  logic [WIDTH-1:0] x;

  // One XOR cell per bit; no carry chain, the sign bit is just another cell.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign x[i] = p[i] ^ q[i];
  end

  // r holds its last value while idle; only out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        r <= x;
      end
    end
  end

`ifdef XOR64_FLAGS_EN
  logic zf_q;
  logic sf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b0;
      sf_q <= 1'b0;
    end else if (in_valid) begin
      zf_q <= (x == '0);
      sf_q <= x[WIDTH-1];
    end
  end

  assign zf = zf_q;
  assign sf = sf_q;
  // XOR can never overflow.
  assign of = 1'b0;
`else
  assign zf = 1'b0;
  assign sf = 1'b0;
  assign of = 1'b0;
`endif

endmodule

// File: tb/tb_xor_64.sv
// tb/tb_xor_64.sv - self-checking bench for xor_64 (flag checks follow XOR64_FLAGS_EN)
module tb_xor_64;

`ifdef XOR64_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] p;
  logic [63:0] q;
  logic [63:0] r;
  logic        out_valid;
  logic        zf;
  logic        sf;
  logic        of;

  int total;
  int bad;

  // Reference state: what the outputs must show after the most recent edge.
  logic [63:0] m_r;
  logic        m_v;
  logic        m_zf;
  logic        m_sf;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] exp_r;
    logic        exp_v;
    logic        exp_zf;
    logic        exp_sf;
  } vec_t;

  vec_t tbl[$];

  xor_64 #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .p         (p),
    .q         (q),
    .r         (r),
    .out_valid (out_valid),
    .zf        (zf),
    .sf        (sf),
    .of        (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a ^ b from the identity a + b = (a ^ b) + 2*(a & b), modulo 2^64.
  function automatic logic [63:0] ref_xor(input logic [63:0] a, input logic [63:0] b);
    return a + b - 64'd2 * (a & b);
  endfunction

  function automatic vec_t mk(input logic rs, input logic iv, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] er, input logic ev,
                              input logic ez, input logic es);
    vec_t v;
    v.rst = rs; v.iv = iv; v.p = a; v.q = b;
    v.exp_r = er; v.exp_v = ev; v.exp_zf = ez; v.exp_sf = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the reference on the edge, sample 1 time unit later.
  task automatic step(input logic rs, input logic iv, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] res;
    rst = rs; in_valid = iv; p = a; q = b;
    @(posedge clk);
    if (rs) begin
      m_r = '0; m_v = 1'b0; m_zf = 1'b0; m_sf = 1'b0;
    end else begin
      m_v = iv;
      if (iv) begin
        res  = ref_xor(a, b);
        m_r  = res;
        m_zf = (res == 64'd0);
        m_sf = ($signed(res) < 0);
      end
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".r"},         r,         m_r);
    chk({tag, ".out_valid"}, out_valid, m_v);
    chk({tag, ".zf"},        zf,        m_zf & FLAGS);
    chk({tag, ".sf"},        sf,        m_sf & FLAGS);
    chk({tag, ".of"},        of,        1'b0);
  endtask

  initial begin
    logic [63:0] ones;
    logic [63:0] pat;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rr;
    logic        rv;
    total = 0; bad = 0;
    ones = '1;
    pat  = 64'h1234_5678_9ABC_DEF0;
    m_r = '0; m_v = 1'b0; m_zf = 1'b0; m_sf = 1'b0;
    rst = 1'b1; in_valid = 1'b0; p = '0; q = '0;

    tbl.push_back(mk(1'b1, 1'b1, ones, ones, 64'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, ones, ones, 64'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, ones, 64'd7, 64'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 64'd69, -64'sd96, 64'hFFFF_FFFF_FFFF_FFE5, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 64'd4,  64'd5, 64'd1,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 64'd14, 64'd9, 64'd7,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 64'd44, 64'd4, 64'd40, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, -64'sd95, 64'd23, 64'hFFFF_FFFF_FFFF_FFB6, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, pat, pat, 64'd0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 64'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 64'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 64'hAAAA_0000_5555_FFFF, 64'h5555_0000_AAAA_0000,
                     64'hFFFF_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b1, 64'd1, 64'd2, 64'd0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 64'd1, 64'd2, 64'd3, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 64'd0, 64'd0, 64'd3, 1'b0, 1'b0, 1'b0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].iv, tbl[i].p, tbl[i].q);
      chk($sformatf("vec%0d.r", i),         r,         tbl[i].exp_r);
      chk($sformatf("vec%0d.out_valid", i), out_valid, tbl[i].exp_v);
      chk($sformatf("vec%0d.zf", i),        zf,        tbl[i].exp_zf & FLAGS);
      chk($sformatf("vec%0d.sf", i),        sf,        tbl[i].exp_sf & FLAGS);
      chk($sformatf("vec%0d.of", i),        of,        1'b0);
    end

    // Randomized traffic: bursts, idles, mid-stream resets, forced zero results.
    for (int n = 0; n < 400; n++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
      rr = ($urandom_range(0, 19) == 0);
      rv = ($urandom_range(0, 9) < 7);
      step(rr, rv, ra, rb);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
